// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle for shift_add_multiplier: the requester drives the i_* signals
// and the multiplier drives the o_* signals.
interface shift_add_multiplier_if #(
    parameter int unsigned N = 8
) ();
    logic           i_start;
    logic           i_signed;
    logic [N-1:0]   i_multiplicand;
    logic [N-1:0]   i_multiplier;
    logic           o_busy;
    logic           o_finished;
    logic [2*N-1:0] o_product;

    modport master (
        output i_start, i_signed, i_multiplicand, i_multiplier,
        input  o_busy, o_finished, o_product
    );

    modport slave (
        input  i_start, i_signed, i_multiplicand, i_multiplier,
        output o_busy, o_finished, o_product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, unsigned or two's complement (sign-magnitude core).
// Optional macro SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are zero.
module shift_add_multiplier #(
    parameter int unsigned N = 8
) (
    input logic                  i_clock,
    input logic                  i_reset,
    shift_add_multiplier_if.slave bus
);
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, NEGATE, DONE} state_t;

    state_t         state, state_nxt;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   mplier_shifted;
    logic [CW-1:0]  count;
    logic           sign_q;
    logic           signed_q;
    logic           accept;
    logic           last_run;
    logic           busy;
    logic           finished;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;

    assign accept = bus.i_start && ((state == IDLE) || (state == DONE));

    // Negating -2^(N-1) in N bits yields the same pattern, which read unsigned is the exact magnitude.
    assign mag_a = (bus.i_signed && bus.i_multiplicand[N-1]) ? ('0 - bus.i_multiplicand)
                                                             : bus.i_multiplicand;
    assign mag_b = (bus.i_signed && bus.i_multiplier[N-1]) ? ('0 - bus.i_multiplier)
                                                           : bus.i_multiplier;

    assign mplier_shifted = mplier >> 1;

`ifdef SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN
    assign last_run = (count == CW'(N - 1)) || (mplier_shifted == '0);
`else
    assign last_run = (count == CW'(N - 1));
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        finished  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_run) state_nxt = signed_q ? NEGATE : DONE;
            end
            NEGATE: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                finished  = 1'b1;
                state_nxt = bus.i_start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            sign_q   <= 1'b0;
            signed_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        mcand    <= {{N{1'b0}}, mag_a};
                        mplier   <= mag_b;
                        acc      <= '0;
                        count    <= '0;
                        signed_q <= bus.i_signed;
                        sign_q   <= bus.i_signed &
                                    (bus.i_multiplicand[N-1] ^ bus.i_multiplier[N-1]);
                    end
                end
                RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier_shifted;
                    count  <= count + CW'(1);
                end
                NEGATE: begin
                    if (sign_q) acc <= '0 - acc;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy     = busy;
    assign bus.o_finished = finished;
    assign bus.o_product  = acc;
endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits; legal range N >= 2.
REQ-002 SHALL have port i_clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_start  input  1  request; accepted only in IDLE or DONE.
REQ-005 SHALL have port i_signed  input  1  operand mode, sampled with i_start: 1 = two's complement, 0 = unsigned.
REQ-006 SHALL have port i_multiplicand  input  N  first operand, sampled on accepted start.
REQ-007 SHALL have port i_multiplier  input  N  second operand, sampled on accepted start.
REQ-008 SHALL have port o_busy  output  1  high in RUN and NEGATE.
REQ-009 SHALL have port o_finished  output  1  one-cycle pulse, high only in DONE.
REQ-010 SHALL have port o_product  output  2N  registered result, valid from DONE until the next accepted start.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, NEGATE, DONE.
REQ-012 SHALL leave IDLE or DONE for RUN on the edge where i_start=1, and SHALL then:
  - load operand magnitudes: absolute value if i_signed=1, raw value otherwise;
  - latch the result sign as the XOR of the operand MSBs when signed, 0 when unsigned;
  - clear the accumulator and the bit counter.
REQ-013 SHALL process one multiplier bit per RUN cycle:
  - if the multiplier LSB is 1, add the 2N-bit multiplicand into the accumulator;
  - shift the multiplicand left by 1 and the multiplier right by 1;
  - increment the bit counter.
REQ-014 SHALL leave RUN after exactly N cycles (macro absent): to NEGATE if the start was signed, else to DONE.
REQ-015 SHALL, in NEGATE (one cycle), two's-complement the accumulator if the latched sign is 1, else hold it; SHALL then go to DONE.
REQ-016 SHALL, in DONE, assert o_finished for exactly one cycle, then go to IDLE unless i_start=1, in which case it goes to RUN.
REQ-017 SHALL give fixed latency from the start edge to o_finished high: N+1 cycles unsigned, N+2 cycles signed.
REQ-018 SHALL ignore i_start, i_signed and the operands while in RUN or NEGATE, with no effect on state or result.
REQ-019 SHALL compute modulo 2^(2N) with no carry-out; the exact product always fits in 2N bits, including -2^(N-1) * -2^(N-1).
REQ-020 SHALL hold the magnitude of -2^(N-1) as an N-bit unsigned value with no overflow.
REQ-021 SHALL hold o_product at its last value in IDLE; it changes only in RUN and NEGATE.

Reset
REQ-022 SHALL, on i_reset=1 at a clock edge and in any state, drive the FSM to IDLE, o_busy=0, o_finished=0, o_product=0, and clear the counter and internal registers.
REQ-023 SHALL give reset priority over a simultaneous i_start; an in-flight operation is discarded with no o_finished pulse.

Configuration
REQ-024 SHALL support macro SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN.
REQ-025 SHALL, when SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN is defined, also leave RUN after any RUN cycle whose post-shift multiplier register is all zero:
  - minimum 1 RUN cycle, maximum N;
  - destination as REQ-014;
  - result identical to the fixed-latency build.
REQ-026 SHALL, when the macro is undefined, have no early-exit logic; RUN is always exactly N cycles.

Verification
REQ-027 SHALL cover: N=8, unsigned, 255*255 -> o_product=0xFE01, o_finished high 9 cycles after the start edge, o_busy high for 8 cycles.
REQ-028 SHALL cover: N=8, signed, -3*5 (0xFD, 0x05) -> o_product=0xFFF1 at cycle 10; -128*-128 (0x80, 0x80) -> 0x4000.
REQ-029 SHALL cover: start 0x12*0x34, then i_start pulsed with 0xFF*0xFF at cycle 3 -> o_product=0x03A8, single o_finished pulse.
REQ-030 SHALL cover: i_reset asserted at cycle 4 of RUN -> next cycle o_busy=0, o_product=0, no o_finished; a new start of 6*7 -> 0x002A.
REQ-031 SHALL cover: back-to-back, i_start held in DONE with 2*3 -> o_finished pulses one cycle apart from RUN re-entry; second o_product=0x0006.
REQ-032 SHALL cover: with SHIFT_ADD_MULTIPLIER_EARLY_EXIT_EN, unsigned 7*1 -> 1 RUN cycle, o_finished at cycle 2, o_product=0x0007; 0*0 -> 1 RUN cycle, o_product=0.
